// File: rtl/alu_ctrl_pkg.sv
// Shared types and opcode constants for the ALU command controller.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        CAPTURE,
        SEND_LO,
        SEND_HI
    } state_t;

    localparam logic [7:0] OPC_BASE = 8'hA0;
    localparam logic [7:0] OPC_MASK = 8'hFC;

    function automatic logic opc_valid(input logic [7:0] b);
        return (b & OPC_MASK) == OPC_BASE;
    endfunction

endpackage

// File: rtl/byte_timeout_cnt.sv
// Inter-byte idle down-counter; expired flags the last allowed idle cycle.
module byte_timeout_cnt #(
    parameter int MAX = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(MAX);
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == W'(1));

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Frame parser driving a logic unit and returning its 16-bit result as two bytes.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [1:0]              ALU_FUN,
    output logic [DATA_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   B,
    output logic                    Logic_Enable,
    input  logic [2*DATA_WIDTH-1:0] Logic_OUT,
    input  logic                    Logic_Flag,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY,
    output logic                    CTRL_BUSY,
    output logic                    FRAME_ERR
);

    state_t                  state;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    flag_q;
    logic                    in_get;
    logic                    opc_ok;
    logic                    tmo_load;
    logic                    tmo_en;
    logic                    tmo_exp;

    assign in_get   = (state == GET_A) || (state == GET_B);
    assign opc_ok   = opc_valid(RX_P_DATA[7:0]);
    assign tmo_load = RX_D_VLD && ((state == IDLE && opc_ok) || state == GET_A);
    assign tmo_en   = in_get && !RX_D_VLD;

    byte_timeout_cnt #(
        .MAX (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (tmo_load),
        .clr     (!in_get),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            result       <= '0;
            flag_q       <= 1'b0;
            ALU_FUN      <= '0;
            A            <= '0;
            B            <= '0;
            Logic_Enable <= 1'b0;
            TX_P_DATA    <= '0;
            TX_D_VLD     <= 1'b0;
            CTRL_BUSY    <= 1'b0;
            FRAME_ERR    <= 1'b0;
        end else begin
            FRAME_ERR    <= 1'b0;
            Logic_Enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (opc_ok) begin
                            ALU_FUN <= RX_P_DATA[1:0];
                            state   <= GET_A;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                end
                GET_A, GET_B: begin
                    // A byte arriving on the expiry cycle wins over the timeout
                    if (RX_D_VLD) begin
                        if (state == GET_A) begin
                            A     <= RX_P_DATA;
                            state <= GET_B;
                        end else begin
                            B            <= RX_P_DATA;
                            Logic_Enable <= 1'b1;
                            CTRL_BUSY    <= 1'b1;
                            state        <= EXEC;
                        end
                    end else if (tmo_exp) begin
                        FRAME_ERR <= 1'b1;
                        ALU_FUN   <= '0;
                        A         <= '0;
                        B         <= '0;
                        state     <= IDLE;
                    end
                end
                EXEC: begin
                    flag_q <= Logic_Flag;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    result <= Logic_OUT;
                    if (flag_q) begin
                        TX_P_DATA <= Logic_OUT[DATA_WIDTH-1:0];
                        TX_D_VLD  <= 1'b1;
                        state     <= SEND_LO;
                    end else begin
                        FRAME_ERR <= 1'b1;
                        CTRL_BUSY <= 1'b0;
                        state     <= IDLE;
                    end
                end
                SEND_LO: begin
                    if (!TX_BUSY) begin
                        TX_P_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                        state     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD  <= 1'b0;
                        TX_P_DATA <= '0;
                        CTRL_BUSY <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed and random frame bench for alu_cmd_ctrl with an emulated logic unit.
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [1:0]  ALU_FUN;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Logic_Enable;
    logic [15:0] Logic_OUT;
    logic        Logic_Flag;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic        CTRL_BUSY;
    logic        FRAME_ERR;

    int n_chk  = 0;
    int n_fail = 0;
    int le_cnt = 0;
    int fe_cnt = 0;
    logic flag_fail = 1'b0;
    logic [15:0] lu_q = '0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    alu_cmd_ctrl #(
        .DATA_WIDTH  (8),
        .TIMEOUT_CYC (1024)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .ALU_FUN      (ALU_FUN),
        .A            (A),
        .B            (B),
        .Logic_Enable (Logic_Enable),
        .Logic_OUT    (Logic_OUT),
        .Logic_Flag   (Logic_Flag),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .CTRL_BUSY    (CTRL_BUSY),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // 16-bit logic unit: AND, OR, XOR, NOR on zero-extended operands
    function automatic logic [15:0] ref_alu(
        input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            2'd0:    return {8'h00, a & b};
            2'd1:    return {8'h00, a | b};
            2'd2:    return {8'h00, a ^ b};
            default: return ~({8'h00, a} | {8'h00, b});
        endcase
    endfunction

    always @(posedge CLK) begin
        if (Logic_Enable) lu_q <= ref_alu(ALU_FUN, A, B);
    end
    assign Logic_OUT  = lu_q;
    assign Logic_Flag = Logic_Enable & ~flag_fail;

    always @(negedge CLK) begin
        if (TX_D_VLD && !TX_BUSY) tx_q.push_back(TX_P_DATA);
        if (Logic_Enable) le_cnt++;
        if (FRAME_ERR) fe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic check_queue(input string tag);
        chk({tag, "_count"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            chk({tag, "_byte"}, tx_q[i], exp_q[i]);
        tx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fun"}, ALU_FUN, 0);
        chk({tag, "_a"}, A, 0);
        chk({tag, "_b"}, B, 0);
        chk({tag, "_le"}, Logic_Enable, 0);
        chk({tag, "_txd"}, TX_P_DATA, 0);
        chk({tag, "_txv"}, TX_D_VLD, 0);
        chk({tag, "_busy"}, CTRL_BUSY, 0);
        chk({tag, "_ferr"}, FRAME_ERR, 0);
    endtask

    // Full frame with TX_BUSY low; gap idle cycles between opcode and A
    task automatic run_frame(input string tag, input logic [7:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input int gap, input logic [7:0] lo,
                             input logic [7:0] hi);
        int le0;
        int fe0;
        le0 = le_cnt;
        fe0 = fe_cnt;
        send_byte(op);
        repeat (gap) tick();
        send_byte(a);
        send_byte(b);
        chk({tag, "_le_on"}, Logic_Enable, 1);
        chk({tag, "_fun"}, ALU_FUN, op[1:0]);
        chk({tag, "_busy"}, CTRL_BUSY, 1);
        tick();
        chk({tag, "_le_off"}, Logic_Enable, 0);
        tick();
        chk({tag, "_lo_vld"}, TX_D_VLD, 1);
        chk({tag, "_lo"}, TX_P_DATA, lo);
        tick();
        chk({tag, "_hi_vld"}, TX_D_VLD, 1);
        chk({tag, "_hi"}, TX_P_DATA, hi);
        tick();
        chk({tag, "_done_vld"}, TX_D_VLD, 0);
        chk({tag, "_done_busy"}, CTRL_BUSY, 0);
        chk({tag, "_le_pulses"}, le_cnt - le0, 1);
        chk({tag, "_no_err"}, fe_cnt - fe0, 0);
        exp_q.push_back(lo);
        exp_q.push_back(hi);
        check_queue(tag);
    endtask

    initial begin
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        int          k;
        int          fe0;
        int          le0;

        RST = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD = 1'b0;
        TX_BUSY = 1'b0;
        tick();
        tick();
        check_zero("reset");
        RST = 1'b1;
        tick();

        run_frame("and", 8'hA0, 8'hF0, 8'h3C, 0, 8'h30, 8'h00);
        run_frame("nor", 8'hA3, 8'h0F, 8'hF0, 0, 8'h00, 8'hFF);

        le0 = le_cnt;
        send_byte(8'h55);
        chk("badop_err", FRAME_ERR, 1);
        chk("badop_busy", CTRL_BUSY, 0);
        tick();
        chk("badop_err_off", FRAME_ERR, 0);
        chk("badop_no_le", le_cnt - le0, 0);
        run_frame("xor", 8'hA2, 8'h5A, 8'h0F, 0, 8'h55, 8'h00);

        fe0 = fe_cnt;
        le0 = le_cnt;
        send_byte(8'hA1);
        send_byte(8'h12);
        k = 0;
        while (FRAME_ERR !== 1'b1 && k < 1100) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 1024);
        tick();
        chk("tmo_err_off", FRAME_ERR, 0);
        chk("tmo_err_pulses", fe_cnt - fe0, 1);
        chk("tmo_no_le", le_cnt - le0, 0);
        chk("tmo_a_cleared", A, 0);
        check_queue("tmo_no_tx");
        run_frame("or_after_tmo", 8'hA1, 8'h12, 8'h21, 0, 8'h33, 8'h00);

        run_frame("tmo_edge", 8'hA0, 8'hFF, 8'h81, 1023, 8'h81, 8'h00);

        fe0 = fe_cnt;
        flag_fail = 1'b1;
        send_byte(8'hA1);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        tick();
        chk("flag_err", FRAME_ERR, 1);
        chk("flag_no_vld", TX_D_VLD, 0);
        chk("flag_busy", CTRL_BUSY, 0);
        flag_fail = 1'b0;
        repeat (3) tick();
        chk("flag_err_pulses", fe_cnt - fe0, 1);
        check_queue("flag_no_tx");

        for (int i = 0; i < 6; i++) begin
            op = 8'hA0 | 8'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            r  = ref_alu(op[1:0], a, b);
            run_frame("rand", op, a, b, $urandom_range(0, 5), r[7:0], r[15:8]);
        end

        fe0 = fe_cnt;
        TX_BUSY = 1'b1;
        send_byte(8'hA2);
        send_byte(8'hC3);
        send_byte(8'h3C);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("busy_hold_vld", TX_D_VLD, 1);
            chk("busy_hold_lo", TX_P_DATA, 8'hFF);
            RX_P_DATA = 8'hA0 | 8'($urandom_range(0, 3));
            RX_D_VLD  = 1'b1;
            tick();
        end
        RX_D_VLD = 1'b0;
        TX_BUSY  = 1'b0;
        tick();
        chk("busy_hi", TX_P_DATA, 8'h00);
        chk("busy_hi_vld", TX_D_VLD, 1);
        tick();
        chk("busy_done", TX_D_VLD, 0);
        chk("busy_no_err", fe_cnt - fe0, 0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        check_queue("busy");

        send_byte(8'hA3);
        send_byte(8'h00);
        send_byte(8'h01);
        tick();
        tick();
        tick();
        chk("rst_pre_hi", TX_P_DATA, 8'hFF);
        RST = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        RST = 1'b1;
        repeat (10) tick();
        chk("rst_after_vld", TX_D_VLD, 0);
        exp_q.push_back(8'hFE);
        check_queue("rst_abort");
        run_frame("post_rst", 8'hA0, 8'h0F, 8'h07, 0, 8'h07, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
